// File: rtl/data_sram_responder.sv
// Data-SRAM slave for the MEM stage: one-cycle registered read, byte-lane writes,
// post-reset clear sweep, plus access counters and a sticky out-of-bounds flag.
module data_sram_responder #(
  parameter int ADDR_W = 12
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        data_sram_en,
  input  logic [3:0]  data_sram_wen,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  output logic [31:0] data_sram_rdata,
  output logic        init_busy,
  output logic [31:0] rd_cnt,
  output logic [31:0] wr_cnt,
  output logic        oob_err
);

  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic {INIT, RUN} state_t;

  state_t            state;
  logic [ADDR_W-1:0] clr_idx;
  logic [31:0]       mem [DEPTH];

  logic [ADDR_W-1:0] idx;
  logic              oob;
  logic              acc;
  logic              is_wr;
  logic              unused_addr;

  assign idx         = data_sram_addr[ADDR_W+1:2];
  assign oob         = |data_sram_addr[31:ADDR_W+2];
  assign acc         = (state == RUN) && data_sram_en && !reset;
  assign is_wr       = |data_sram_wen;
  assign unused_addr = ^data_sram_addr[1:0];

  // Array port: the clear sweep takes priority over requests.
  always_ff @(posedge clk) begin
    if (state == INIT) begin
      mem[clr_idx] <= '0;
    end else if (acc && is_wr && !oob) begin
      for (int i = 0; i < 4; i++) begin
        if (data_sram_wen[i]) mem[idx][8*i +: 8] <= data_sram_wdata[8*i +: 8];
      end
    end
  end

  // Control, read data and trace counters. Reads sample mem before the
  // same-edge write lands, so a store returns the pre-write word.
  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= INIT;
      clr_idx         <= '0;
      init_busy       <= 1'b1;
      data_sram_rdata <= '0;
      rd_cnt          <= '0;
      wr_cnt          <= '0;
      oob_err         <= 1'b0;
    end else begin
      case (state)
        INIT: begin
          clr_idx <= clr_idx + 1'b1;
          if (clr_idx == {ADDR_W{1'b1}}) begin
            state     <= RUN;
            init_busy <= 1'b0;
          end
        end
        RUN: begin
          if (acc) begin
            data_sram_rdata <= oob ? 32'h0 : mem[idx];
            if (oob) oob_err <= 1'b1;
            if (is_wr) wr_cnt <= wr_cnt + 32'd1;
            else       rd_cnt <= rd_cnt + 32'd1;
          end
        end
        default: state <= INIT;
      endcase
    end
  end

endmodule

// File: tb/tb_data_sram_responder.sv
// Directed bench for data_sram_responder with ADDR_W=4 (16-word array).
module tb_data_sram_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic        data_sram_en;
  logic [3:0]  data_sram_wen;
  logic [31:0] data_sram_addr;
  logic [31:0] data_sram_wdata;
  logic [31:0] data_sram_rdata;
  logic        init_busy;
  logic [31:0] rd_cnt;
  logic [31:0] wr_cnt;
  logic        oob_err;

  int n_tests = 0;
  int n_fail  = 0;
  int n_init;

  data_sram_responder #(.ADDR_W(4)) dut (
    .clk             (clk),
    .reset           (reset),
    .data_sram_en    (data_sram_en),
    .data_sram_wen   (data_sram_wen),
    .data_sram_addr  (data_sram_addr),
    .data_sram_wdata (data_sram_wdata),
    .data_sram_rdata (data_sram_rdata),
    .init_busy       (init_busy),
    .rd_cnt          (rd_cnt),
    .wr_cnt          (wr_cnt),
    .oob_err         (oob_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One-cycle access; on return the registered response is visible.
  task automatic access(input logic [31:0] addr, input logic [3:0] wen, input logic [31:0] wdata);
    data_sram_en    = 1'b1;
    data_sram_addr  = addr;
    data_sram_wen   = wen;
    data_sram_wdata = wdata;
    tick();
    data_sram_en    = 1'b0;
    data_sram_wen   = 4'h0;
  endtask

  // Counts cycles with init_busy high, starting just after the reset edge.
  // A write to word 0 is issued at sweep cycle 3 and must be dropped.
  task automatic pulse_reset_and_sweep(input bit poke, output int n);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rst_rdata", data_sram_rdata, 32'h0);
    check("rst_rd_cnt", rd_cnt, 32'h0);
    check("rst_wr_cnt", wr_cnt, 32'h0);
    check("rst_oob", {31'h0, oob_err}, 32'h0);
    check("rst_busy", {31'h0, init_busy}, 32'h1);
    n = 0;
    while (init_busy === 1'b1 && n < 100) begin
      n++;
      if (poke && n == 3) begin
        data_sram_en    = 1'b1;
        data_sram_wen   = 4'hF;
        data_sram_addr  = 32'h0;
        data_sram_wdata = 32'hFFFF_FFFF;
      end else begin
        data_sram_en  = 1'b0;
        data_sram_wen = 4'h0;
      end
      tick();
    end
    data_sram_en  = 1'b0;
    data_sram_wen = 4'h0;
  endtask

  initial begin
    reset           = 1'b1;
    data_sram_en    = 1'b0;
    data_sram_wen   = 4'h0;
    data_sram_addr  = 32'h0;
    data_sram_wdata = 32'h0;

    pulse_reset_and_sweep(1'b1, n_init);
    check("init_len", n_init, 32'd16);
    check("init_drop_wr_cnt", wr_cnt, 32'h0);
    check("init_drop_rd_cnt", rd_cnt, 32'h0);
    check("init_drop_rdata", data_sram_rdata, 32'h0);

    access(32'h0, 4'h0, 32'h0);
    check("rd_word0_cleared", data_sram_rdata, 32'h0);
    access(32'h3C, 4'h0, 32'h0);
    check("rd_3c_cleared", data_sram_rdata, 32'h0);
    check("rd_cnt_2", rd_cnt, 32'd2);

    access(32'h8, 4'hF, 32'h1122_3344);
    access(32'h8, 4'b0100, 32'hAABB_CCDD);
    check("wr_read_first_lane", data_sram_rdata, 32'h1122_3344);
    access(32'h8, 4'h0, 32'h0);
    check("byte_lane_merge", data_sram_rdata, 32'h11BB_3344);
    check("wr_cnt_2", wr_cnt, 32'd2);
    check("rd_cnt_3", rd_cnt, 32'd3);

    access(32'h4, 4'hF, 32'h55);
    access(32'h4, 4'hF, 32'h66);
    check("read_first", data_sram_rdata, 32'h55);
    access(32'h4, 4'h0, 32'h0);
    check("b2b_wr_rd", data_sram_rdata, 32'h66);

    for (int i = 0; i < 5; i++) tick();
    check("hold_rdata", data_sram_rdata, 32'h66);
    check("oob_clear_before", {31'h0, oob_err}, 32'h0);

    access(32'h40, 4'h0, 32'h0);
    check("oob_rd_rdata", data_sram_rdata, 32'h0);
    check("oob_set", {31'h0, oob_err}, 32'h1);
    access(32'h44, 4'hF, 32'hDEAD_BEEF);
    check("oob_wr_rdata", data_sram_rdata, 32'h0);
    access(32'h4, 4'h0, 32'h0);
    check("oob_wr_no_alias", data_sram_rdata, 32'h66);
    check("oob_sticky", {31'h0, oob_err}, 32'h1);
    check("rd_cnt_6", rd_cnt, 32'd6);
    check("wr_cnt_5", wr_cnt, 32'd5);

    access(32'hC, 4'hF, 32'h1234_5678);
    access(32'h8, 4'h0, 32'h0);
    check("pre_reset_rdata", data_sram_rdata, 32'h11BB_3344);
    pulse_reset_and_sweep(1'b0, n_init);
    check("reinit_len", n_init, 32'd16);
    access(32'hC, 4'h0, 32'h0);
    check("reinit_cleared", data_sram_rdata, 32'h0);
    check("reinit_rd_cnt", rd_cnt, 32'd1);
    check("reinit_wr_cnt", wr_cnt, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
